pong_engine: RTL and testbench

PONG_ENGINE -- requirements
Module: pong_engine

---
 rtl/pong_engine_if.sv | 30 +++
 rtl/pong_engine.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_pong_engine.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pong_engine_if.sv
// Control and status bundle between a game controller and the pong engine.
// The engine uses the slave modport; the controller or bench uses master.
interface pong_engine_if;
    logic        tick;
    logic        start;
    logic        pause;
    logic [9:0]  p1_pos;
    logic [9:0]  p2_pos;
    logic [10:0] ball_x;
    logic [9:0]  ball_y;
    logic [9:0]  pad1_y;
    logic [9:0]  pad2_y;
    logic [3:0]  score1;
    logic [3:0]  score2;
    logic        serving;
    logic        game_over;
    logic        winner;

    modport master (
        output tick, start, pause, p1_pos, p2_pos,
        input  ball_x, ball_y, pad1_y, pad2_y, score1, score2,
               serving, game_over, winner
    );

    modport slave (
        input  tick, start, pause, p1_pos, p2_pos,
        output ball_x, ball_y, pad1_y, pad2_y, score1, score2,
               serving, game_over, winner
    );
endinterface

// File: rtl/pong_engine.sv
// Two-player pong game engine: paddle clamping, ball motion with wall bounces,
// paddle hits with speed-up, scoring, serve delay and game-over handling.
module pong_engine #(
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned SCREEN_H    = 480,
    parameter int unsigned BALL_SIZE   = 10,
    parameter int unsigned PAD_W       = 10,
    parameter int unsigned PAD_H       = 50,
    parameter int unsigned PAD1_X      = 40,
    parameter int unsigned PAD2_X      = 600,
    parameter int unsigned MAX_SPEED   = 7,
    parameter int unsigned WIN_SCORE   = 9,
    parameter int unsigned SERVE_DELAY = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    pong_engine_if.slave bus
);

    localparam int unsigned AW = 12;
    localparam int unsigned VW = 4;
    localparam int unsigned SW = 4;
    localparam int unsigned XW = 11;
    localparam int unsigned YW = 10;

    localparam logic [AW-1:0] X_MAX     = AW'(SCREEN_W - BALL_SIZE);
    localparam logic [AW-1:0] Y_MAX     = AW'(SCREEN_H - BALL_SIZE);
    localparam logic [AW-1:0] X_CENTRE  = AW'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [AW-1:0] Y_CENTRE  = AW'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [AW-1:0] PAD_Y_MAX = AW'(SCREEN_H - PAD_H);
    localparam logic [AW-1:0] BALL_SZ   = AW'(BALL_SIZE);
    localparam logic [AW-1:0] HALF_BALL = AW'(BALL_SIZE / 2);
    localparam logic [AW-1:0] PAD_HGT   = AW'(PAD_H);
    localparam logic [AW-1:0] P1_LEFT   = AW'(PAD1_X);
    localparam logic [AW-1:0] P1_RIGHT  = AW'(PAD1_X + PAD_W);
    localparam logic [AW-1:0] P2_LEFT   = AW'(PAD2_X);
    localparam logic [AW-1:0] P2_RIGHT  = AW'(PAD2_X + PAD_W);
    localparam logic [AW-1:0] SERVE_END = AW'(SERVE_DELAY - 1);
    localparam logic [VW-1:0] V_MAX     = VW'(MAX_SPEED);
    localparam logic [VW-1:0] V_INIT    = VW'(1);
    localparam logic [SW-1:0] WIN       = SW'(WIN_SCORE);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SERVE  = 3'd1,
        MOVE   = 3'd2,
        CHECK  = 3'd3,
        SCORED = 3'd4,
        OVER   = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [XW-1:0]   ball_x_q, ball_x_d;
    logic [YW-1:0]   ball_y_q, ball_y_d;
    logic [YW-1:0]   pad1_q, pad1_d;
    logic [YW-1:0]   pad2_q, pad2_d;
    logic [SW-1:0]   score1_q, score1_d;
    logic [SW-1:0]   score2_q, score2_d;
    logic [VW-1:0]   vx_q, vx_d;
    logic [VW-1:0]   vy_q, vy_d;
    logic            dir_x_q, dir_x_d;   // 1 = right
    logic            dir_y_q, dir_y_d;   // 1 = down
    logic            goal1_q, goal1_d;
    logic            goal2_q, goal2_d;
    logic [AW-1:0]   serve_cnt_q, serve_cnt_d;
    logic            serving_q, serving_d;
    logic            game_over_q, game_over_d;
    logic            winner_q, winner_d;

    logic            tick_en;
    logic [AW-1:0]   bx, by, vx12, vy12, pad1_12, pad2_12, mid_y;
    logic [AW-1:0]   p1_req, p2_req;
    logic            hit1, hit2;
    logic [AW-1:0]   mv_x, mv_y;
    logic            mv_dir_y, mv_goal1, mv_goal2;
    logic [SW-1:0]   score1_inc, score2_inc;

    function automatic logic [VW-1:0] speed_up(input logic [VW-1:0] v);
        return (v >= V_MAX) ? V_MAX : v + VW'(1);
    endfunction

    assign tick_en = bus.tick & ~bus.pause;
    assign bx      = AW'(ball_x_q);
    assign by      = AW'(ball_y_q);
    assign vx12    = AW'(vx_q);
    assign vy12    = AW'(vy_q);
    assign pad1_12 = AW'(pad1_q);
    assign pad2_12 = AW'(pad2_q);
    assign p1_req  = AW'(bus.p1_pos);
    assign p2_req  = AW'(bus.p2_pos);
    assign mid_y   = by + HALF_BALL;

    // Paddle contact tests on the current ball position (used in CHECK).
    assign hit1 = (bx >= P1_LEFT) && (bx < P1_RIGHT) &&
                  (mid_y >= pad1_12) && (mid_y < pad1_12 + PAD_HGT);
    assign hit2 = (bx + BALL_SZ >= P2_LEFT) && (bx + BALL_SZ < P2_RIGHT) &&
                  (mid_y >= pad2_12) && (mid_y < pad2_12 + PAD_HGT);

    assign score1_inc = (score1_q < WIN) ? score1_q + SW'(1) : score1_q;
    assign score2_inc = (score2_q < WIN) ? score2_q + SW'(1) : score2_q;

    // One ball advance with wall clamping; side walls raise a goal flag.
    always_comb begin
        mv_x     = bx;
        mv_y     = by;
        mv_dir_y = dir_y_q;
        mv_goal1 = 1'b0;
        mv_goal2 = 1'b0;
        if (dir_y_q) begin
            if (by + vy12 >= Y_MAX) begin
                mv_y     = Y_MAX;
                mv_dir_y = 1'b0;
            end else begin
                mv_y = by + vy12;
            end
        end else begin
            if (by < vy12) begin
                mv_y     = '0;
                mv_dir_y = 1'b1;
            end else begin
                mv_y = by - vy12;
            end
        end
        if (dir_x_q) begin
            if (bx + vx12 >= X_MAX) begin
                mv_x     = X_MAX;
                mv_goal1 = 1'b1;
            end else begin
                mv_x = bx + vx12;
            end
        end else begin
            if (bx < vx12) begin
                mv_x     = '0;
                mv_goal2 = 1'b1;
            end else begin
                mv_x = bx - vx12;
            end
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        pad1_d      = pad1_q;
        pad2_d      = pad2_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        vx_d        = vx_q;
        vy_d        = vy_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        goal1_d     = goal1_q;
        goal2_d     = goal2_q;
        serve_cnt_d = serve_cnt_q;
        winner_d    = winner_q;

        if (tick_en) begin
            pad1_d = YW'((p1_req > PAD_Y_MAX) ? PAD_Y_MAX : p1_req);
            pad2_d = YW'((p2_req > PAD_Y_MAX) ? PAD_Y_MAX : p2_req);
        end

        unique case (state_q)
            IDLE, OVER: begin
                if (bus.start) begin
                    state_d     = SERVE;
                    score1_d    = '0;
                    score2_d    = '0;
                    ball_x_d    = XW'(X_CENTRE);
                    ball_y_d    = YW'(Y_CENTRE);
                    vx_d        = V_INIT;
                    vy_d        = V_INIT;
                    dir_x_d     = 1'b1;
                    dir_y_d     = 1'b1;
                    goal1_d     = 1'b0;
                    goal2_d     = 1'b0;
                    serve_cnt_d = '0;
                    winner_d    = 1'b0;
                end
            end
            SERVE: begin
                if (tick_en) begin
                    if (serve_cnt_q >= SERVE_END) begin
                        serve_cnt_d = '0;
                        state_d     = MOVE;
                    end else begin
                        serve_cnt_d = serve_cnt_q + AW'(1);
                    end
                end
            end
            MOVE: begin
                if (tick_en) begin
                    ball_x_d = XW'(mv_x);
                    ball_y_d = YW'(mv_y);
                    dir_y_d  = mv_dir_y;
                    goal1_d  = mv_goal1;
                    goal2_d  = mv_goal2;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                // A goal outranks a paddle hit on the same frame.
                if (goal1_q || goal2_q) begin
                    state_d = SCORED;
                end else if ((dir_x_q && hit2) || (!dir_x_q && hit1)) begin
                    dir_x_d = ~dir_x_q;
                    vx_d    = speed_up(vx_q);
                    vy_d    = speed_up(vy_q);
                    state_d = MOVE;
                end else begin
                    state_d = MOVE;
                end
            end
            SCORED: begin
                ball_x_d    = XW'(X_CENTRE);
                ball_y_d    = YW'(Y_CENTRE);
                vx_d        = V_INIT;
                vy_d        = V_INIT;
                dir_y_d     = 1'b1;
                goal1_d     = 1'b0;
                goal2_d     = 1'b0;
                serve_cnt_d = '0;
                state_d     = SERVE;
                if (goal1_q) begin
                    score1_d = score1_inc;
                    dir_x_d  = 1'b1;
                    if (score1_inc == WIN) begin
                        winner_d = 1'b0;
                        state_d  = OVER;
                    end
                end else if (goal2_q) begin
                    score2_d = score2_inc;
                    dir_x_d  = 1'b0;
                    if (score2_inc == WIN) begin
                        winner_d = 1'b1;
                        state_d  = OVER;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        serving_d   = (state_d == SERVE);
        game_over_d = (state_d == OVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ball_x_q    <= XW'(X_CENTRE);
            ball_y_q    <= YW'(Y_CENTRE);
            pad1_q      <= '0;
            pad2_q      <= '0;
            score1_q    <= '0;
            score2_q    <= '0;
            vx_q        <= V_INIT;
            vy_q        <= V_INIT;
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            goal1_q     <= 1'b0;
            goal2_q     <= 1'b0;
            serve_cnt_q <= '0;
            serving_q   <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            pad1_q      <= pad1_d;
            pad2_q      <= pad2_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            vx_q        <= vx_d;
            vy_q        <= vy_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            goal1_q     <= goal1_d;
            goal2_q     <= goal2_d;
            serve_cnt_q <= serve_cnt_d;
            serving_q   <= serving_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

    assign bus.ball_x    = ball_x_q;
    assign bus.ball_y    = ball_y_q;
    assign bus.pad1_y    = pad1_q;
    assign bus.pad2_y    = pad2_q;
    assign bus.score1    = score1_q;
    assign bus.score2    = score2_q;
    assign bus.serving   = serving_q;
    assign bus.game_over = game_over_q;
    assign bus.winner    = winner_q;

endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine: a hand-computed rally table covering serve,
// wall bounces, both paddle hits, goals for each player and a full game.
module tb_pong_engine;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    pong_engine_if bus ();

    pong_engine dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int steps;   // ticks to issue
        bit st;      // start pulse before the ticks
        bit pz;      // pause held during the ticks
        int p2;      // p2_pos during the ticks
        int x;
        int y;
        int s1;
        int s2;
        int sv;
        int ov;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(int steps, bit st, bit pz, int p2, int x, int y,
                                int s1, int s2, int sv, int ov);
        vec_t v;
        v.steps = steps; v.st = st; v.pz = pz; v.p2 = p2;
        v.x = x; v.y = y; v.s1 = s1; v.s2 = s2; v.sv = sv; v.ov = ov;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_ball(input string tag, input int x, input int y);
        chk({tag, ".ball_x"}, int'(bus.ball_x), x);
        chk({tag, ".ball_y"}, int'(bus.ball_y), y);
    endtask

    // One game tick followed by two idle clocks so CHECK and SCORED settle.
    task automatic step();
        @(negedge clk) bus.tick = 1'b1;
        @(negedge clk) bus.tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_ball(tag, 315, 235);
        chk({tag, ".pad1_y"},    int'(bus.pad1_y), 0);
        chk({tag, ".pad2_y"},    int'(bus.pad2_y), 0);
        chk({tag, ".score1"},    int'(bus.score1), 0);
        chk({tag, ".score2"},    int'(bus.score2), 0);
        chk({tag, ".serving"},   int'(bus.serving), 0);
        chk({tag, ".game_over"}, int'(bus.game_over), 0);
        chk({tag, ".winner"},    int'(bus.winner), 0);
    endtask

    initial begin
        bus.tick   = 1'b0;
        bus.start  = 1'b0;
        bus.pause  = 1'b0;
        bus.p1_pos = 10'd0;
        bus.p2_pos = 10'd0;

        // Point 1: right paddle at 400 returns the ball; player 2 scores on the left wall.
        tv.push_back(mk( 10, 0, 0, 400, 315, 235, 0, 0, 1, 0));
        tv.push_back(mk( 21, 1, 0, 400, 315, 235, 0, 0, 1, 0));
        tv.push_back(mk(  1, 0, 0, 400, 315, 235, 0, 0, 0, 0));
        tv.push_back(mk(  1, 0, 0, 400, 316, 236, 0, 0, 0, 0));
        tv.push_back(mk( 10, 0, 1, 400, 316, 236, 0, 0, 0, 0));
        tv.push_back(mk(233, 0, 0, 400, 549, 469, 0, 0, 0, 0));
        tv.push_back(mk(  1, 1, 0, 400, 550, 470, 0, 0, 0, 0));
        tv.push_back(mk(  1, 0, 0, 400, 551, 469, 0, 0, 0, 0));
        tv.push_back(mk( 39, 0, 0, 400, 590, 430, 0, 0, 0, 0));
        tv.push_back(mk(  1, 0, 0, 400, 588, 428, 0, 0, 0, 0));
        tv.push_back(mk(213, 0, 0, 400, 162,   2, 0, 0, 0, 0));
        tv.push_back(mk(  1, 0, 0, 400, 160,   0, 0, 0, 0, 0));
        tv.push_back(mk(  1, 0, 0, 400, 158,   0, 0, 0, 0, 0));
        tv.push_back(mk(  1, 0, 0, 400, 156,   2, 0, 0, 0, 0));
        tv.push_back(mk( 78, 0, 0, 400,   0, 158, 0, 0, 0, 0));
        tv.push_back(mk(  1, 0, 0, 400, 315, 235, 0, 1, 1, 0));
        // Point 2: serve to the left, left paddle at 400 returns it; player 1 scores.
        tv.push_back(mk( 32, 0, 0, 400, 315, 235, 0, 1, 0, 0));
        tv.push_back(mk(  1, 0, 0, 400, 314, 236, 0, 1, 0, 0));
        tv.push_back(mk(233, 0, 0, 400,  81, 469, 0, 1, 0, 0));
        tv.push_back(mk(  1, 0, 0, 400,  80, 470, 0, 1, 0, 0));
        tv.push_back(mk( 31, 0, 0, 400,  49, 439, 0, 1, 0, 0));
        tv.push_back(mk(  1, 0, 0, 400,  51, 437, 0, 1, 0, 0));
        tv.push_back(mk(218, 0, 0, 400, 487,   1, 0, 1, 0, 0));
        tv.push_back(mk(  1, 0, 0, 400, 489,   0, 0, 1, 0, 0));
        tv.push_back(mk(  1, 0, 0, 400, 491,   2, 0, 1, 0, 0));
        tv.push_back(mk( 69, 0, 0, 400, 629, 140, 0, 1, 0, 0));
        tv.push_back(mk(  1, 0, 0,   0, 315, 235, 1, 1, 1, 0));
        // Points 3..10: right paddle parked at the top, player 1 scores every rally.
        for (int p = 2; p <= 9; p++) begin
            tv.push_back(mk( 32, 0, 0, 0, 315, 235, p - 1, 1, 0, 0));
            tv.push_back(mk(275, 0, 0, 0, 590, 430, p - 1, 1, 0, 0));
            if (p < 9) tv.push_back(mk(40, 0, 0, 0, 315, 235, p, 1, 1, 0));
            else       tv.push_back(mk(40, 0, 0, 0, 315, 235, 9, 1, 0, 1));
        end

        #1 rst_n = 1'b0;
        #2 chk_reset_vals("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Paddle clamping and pause masking while idle.
        bus.p1_pos = 10'd1000;
        bus.p2_pos = 10'd431;
        step();
        chk("clamp.pad1_y", int'(bus.pad1_y), 430);
        chk("clamp.pad2_y", int'(bus.pad2_y), 430);
        chk("idle.serving", int'(bus.serving), 0);
        bus.pause  = 1'b1;
        bus.p1_pos = 10'd5;
        step();
        bus.pause  = 1'b0;
        chk("pause.pad1_y", int'(bus.pad1_y), 430);
        bus.p1_pos = 10'd400;
        bus.p2_pos = 10'd400;
        step();
        chk("pads.pad1_y", int'(bus.pad1_y), 400);
        chk("pads.pad2_y", int'(bus.pad2_y), 400);
        chk_ball("idle", 315, 235);

        pulse_start();
        chk("start.serving", int'(bus.serving), 1);
        chk("start.score1",  int'(bus.score1), 0);

        for (int i = 0; i < tv.size(); i++) begin
            bus.p2_pos = 10'(tv[i].p2);
            if (tv[i].st) pulse_start();
            bus.pause = tv[i].pz;
            repeat (tv[i].steps) step();
            bus.pause = 1'b0;
            chk_ball($sformatf("v%0d", i), tv[i].x, tv[i].y);
            chk($sformatf("v%0d.score1", i),    int'(bus.score1), tv[i].s1);
            chk($sformatf("v%0d.score2", i),    int'(bus.score2), tv[i].s2);
            chk($sformatf("v%0d.serving", i),   int'(bus.serving), tv[i].sv);
            chk($sformatf("v%0d.game_over", i), int'(bus.game_over), tv[i].ov);
        end

        chk("over.winner", int'(bus.winner), 0);
        repeat (5) step();
        chk_ball("over_hold", 315, 235);
        chk("over_hold.score1",    int'(bus.score1), 9);
        chk("over_hold.score2",    int'(bus.score2), 1);
        chk("over_hold.game_over", int'(bus.game_over), 1);
        chk("over_hold.winner",    int'(bus.winner), 0);

        pulse_start();
        chk("restart.score1",    int'(bus.score1), 0);
        chk("restart.score2",    int'(bus.score2), 0);
        chk("restart.game_over", int'(bus.game_over), 0);
        chk("restart.serving",   int'(bus.serving), 1);

        repeat (32) step();
        repeat (3) step();
        chk_ball("premid", 318, 238);

        // Asynchronous reset in the middle of a clock cycle during MOVE.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midreset");
        @(negedge clk) rst_n = 1'b1;
        repeat (3) step();
        chk("postreset.serving", int'(bus.serving), 0);
        chk_ball("postreset", 315, 235);
        chk("postreset.pad1_y", int'(bus.pad1_y), 400);
        chk("postreset.pad2_y", int'(bus.pad2_y), 0);
        pulse_start();
        chk("postreset_start.serving", int'(bus.serving), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
